// File: rtl/fpu_issue_if.sv
// Decode-to-FPU issue/writeback bundle: request in, start strobe and writeback out.
interface fpu_issue_if #(parameter int TAG_W = 6);
  logic             in_valid;
  logic [3:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             in_ready;
  logic             issue_valid;
  logic [2:0]       issue_unit;
  logic [1:0]       issue_sub;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic             wb_illegal;
  logic             div_busy;

  modport master (output in_valid, in_op, in_tag,
                  input  in_ready, issue_valid, issue_unit, issue_sub,
                         wb_valid, wb_tag, wb_illegal, div_busy);
  modport slave  (input  in_valid, in_op, in_tag,
                  output in_ready, issue_valid, issue_unit, issue_sub,
                         wb_valid, wb_tag, wb_illegal, div_busy);
endinterface

// File: rtl/fpu_issue_sched.sv
// FPU issue scheduler: one op per cycle, fixed-latency writeback port reservation,
// iterative div/sqrt occupancy tracking.
module fpu_issue_sched #(
  parameter int TAG_W   = 6,
  parameter int LAT_ADD = 2,
  parameter int LAT_MUL = 2,
  parameter int LAT_DIV = 10,
  parameter int LAT_CVT = 1,
  parameter int MAX_LAT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  fpu_issue_if.slave  bus
);
  localparam int LW = $clog2(MAX_LAT + 1);
  localparam int CW = $clog2(LAT_DIV + 1);

  typedef struct packed {
    logic             vld;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } ent_t;

  // r_tab[k] reaches the writeback registers k+1 edges from now
  ent_t [MAX_LAT-1:0] r_tab;
  ent_t [MAX_LAT-1:0] w_ins;
  ent_t               r_wb;
  logic [CW-1:0]      r_cnt;
  logic               r_iv;
  logic [2:0]         r_unit;
  logic [1:0]         r_sub;

  logic [LW-1:0] w_lat;
  logic [2:0]    w_unit;
  logic [1:0]    w_sub;
  logic          w_isdiv, w_ill, w_slot, w_rdy, w_acc;

  always_comb begin
    w_lat   = LW'(LAT_CVT);
    w_unit  = 3'd4;
    w_sub   = 2'd0;
    w_isdiv = 1'b0;
    w_ill   = 1'b0;
    case (bus.in_op)
      4'd0: begin w_lat = LW'(LAT_ADD); w_unit = 3'd0; end
      4'd1: begin w_lat = LW'(LAT_ADD); w_unit = 3'd0; w_sub = 2'd1; end
      4'd2: begin w_lat = LW'(LAT_MUL); w_unit = 3'd1; end
      4'd3: begin w_lat = LW'(LAT_DIV); w_unit = 3'd2; w_isdiv = 1'b1; end
      4'd4: begin w_lat = LW'(LAT_DIV); w_unit = 3'd2; w_sub = 2'd1; w_isdiv = 1'b1; end
      4'd5: w_unit = 3'd3;
      4'd6: begin w_unit = 3'd3; w_sub = 2'd1; end
      4'd7: begin w_unit = 3'd3; w_sub = 2'd2; end
      default: w_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_slot = 1'b0;
    for (int k = 0; k < MAX_LAT; k++)
      if (w_lat == LW'(k + 1)) w_slot = r_tab[k].vld;
  end

  // A div may issue on the edge where the counter would hit zero
  assign w_rdy = !rst && !flush && !w_slot && !(w_isdiv && (r_cnt > CW'(1)));
  assign w_acc = bus.in_valid && w_rdy;

  always_comb begin
    w_ins = r_tab;
    for (int k = 0; k < MAX_LAT; k++)
      if (w_acc && (w_lat == LW'(k + 1))) w_ins[k] = '{vld: 1'b1, ill: w_ill, tag: bus.in_tag};
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_tab <= '0;
      r_wb  <= '0;
      r_cnt <= '0;
    end else begin
      r_wb <= w_ins[0];
      for (int k = 0; k < MAX_LAT - 1; k++) r_tab[k] <= w_ins[k+1];
      r_tab[MAX_LAT-1] <= '0;
      if (w_acc && w_isdiv)     r_cnt <= CW'(LAT_DIV);
      else if (r_cnt != '0)     r_cnt <= r_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_iv   <= 1'b0;
      r_unit <= '0;
      r_sub  <= '0;
    end else begin
      r_iv <= w_acc;
      if (w_acc) begin
        r_unit <= w_unit;
        r_sub  <= w_sub;
      end
    end
  end

  assign bus.in_ready    = w_rdy;
  assign bus.issue_valid = r_iv;
  assign bus.issue_unit  = r_unit;
  assign bus.issue_sub   = r_sub;
  assign bus.wb_valid    = r_wb.vld;
  assign bus.wb_tag      = r_wb.tag;
  assign bus.wb_illegal  = r_wb.ill;
  assign bus.div_busy    = (r_cnt != '0);
endmodule

// File: tb/tb_fpu_issue_sched.sv
// Random + directed bench for fpu_issue_sched against a cycle-indexed booking model.
module tb_fpu_issue_sched;
  localparam int TAG_W   = 6;
  localparam int LAT_DIV = 10;
  localparam int MAX_LAT = 16;
  localparam int N       = 4096;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  fpu_issue_if #(.TAG_W(TAG_W)) bus();
  fpu_issue_sched #(.TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0, n_vec = 0, n_err = 0, div_free = 0;
  bit known = 0, m_rdy;
  // Model indexed by the period that follows edge n
  bit               bk_v[N];
  bit               bk_ill[N];
  logic [TAG_W-1:0] bk_tag[N];
  bit               ex_iv[N];
  int               ex_iu[N], ex_is[N];
  logic d_rdy, d_iv, d_wbv, d_ill, d_busy;
  logic [2:0] d_iu;
  logic [1:0] d_is;
  logic [TAG_W-1:0] d_tag;

  function automatic int lat(logic [3:0] op);
    case (op)
      4'd0, 4'd1, 4'd2: return 2;
      4'd3, 4'd4:       return LAT_DIV;
      default:          return 1;
    endcase
  endfunction

  function automatic int unit_of(logic [3:0] op);
    case (op)
      4'd0, 4'd1:       return 0;
      4'd2:             return 1;
      4'd3, 4'd4:       return 2;
      4'd5, 4'd6, 4'd7: return 3;
      default:          return 4;
    endcase
  endfunction

  function automatic int sub_of(logic [3:0] op);
    case (op)
      4'd1, 4'd4, 4'd6: return 1;
      4'd7:             return 2;
      default:          return 0;
    endcase
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got %0d want %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic step(bit v, logic [3:0] op, logic [TAG_W-1:0] tag, bit fl, bit rs);
    int a, l;
    @(negedge clk);
    bus.in_valid = v; bus.in_op = op; bus.in_tag = tag; flush = fl; rst = rs;
    #1;
    a = cyc + 1;
    l = lat(op);
    m_rdy = !rs && !fl && !bk_v[a+l-1] && !((op == 4'd3 || op == 4'd4) && a < div_free);
    d_rdy = bus.in_ready; d_iv = bus.issue_valid; d_iu = bus.issue_unit; d_is = bus.issue_sub;
    d_wbv = bus.wb_valid; d_tag = bus.wb_tag; d_ill = bus.wb_illegal; d_busy = bus.div_busy;
    chk("in_ready", int'(d_rdy), int'(m_rdy));
    if (known) begin
      chk("issue_valid", int'(d_iv), int'(ex_iv[cyc]));
      if (ex_iv[cyc]) begin
        chk("issue_unit", int'(d_iu), ex_iu[cyc]);
        chk("issue_sub", int'(d_is), ex_is[cyc]);
      end
      chk("wb_valid", int'(d_wbv), int'(bk_v[cyc]));
      if (bk_v[cyc]) begin
        chk("wb_tag", int'(d_tag), int'(bk_tag[cyc]));
        chk("wb_illegal", int'(d_ill), int'(bk_ill[cyc]));
      end
      chk("div_busy", int'(d_busy), int'(cyc < div_free));
    end
    @(posedge clk);
    cyc++;
    if (rs || fl) begin
      for (int k = a; k <= a + MAX_LAT; k++) bk_v[k] = 0;
      div_free = a;
    end
    if (rs) known = 1;
    if (v && m_rdy) begin
      ex_iv[a] = 1; ex_iu[a] = unit_of(op); ex_is[a] = sub_of(op);
      bk_v[a+l-1] = 1; bk_tag[a+l-1] = tag; bk_ill[a+l-1] = (op > 4'd7);
      if (op == 4'd3 || op == 4'd4) div_free = a + LAT_DIV;
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 4'd0, '0, 0, 0);
  endtask

  initial begin
    bit pv, fl, rs;
    logic [3:0] pop;
    logic [TAG_W-1:0] ptag;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_tag = '0;

    // Reset held with an op offered
    for (int i = 0; i < 3; i++) begin
      step(1, 4'd0, 6'd5, 0, 1);
      chk("rst_ready", int'(d_rdy), 0);
    end
    // fadd tag 5: first accept right after reset
    step(1, 4'd0, 6'd5, 0, 0);
    chk("lit_add_rdy", int'(d_rdy), 1);
    chk("lit_rst_iv", int'(d_iv), 0);
    chk("lit_rst_wb", int'(d_wbv), 0);
    step(0, 4'd0, '0, 0, 0);
    chk("lit_add_iv", int'(d_iv), 1);
    chk("lit_add_unit", int'(d_iu), 0);
    chk("lit_add_wb_early", int'(d_wbv), 0);
    step(0, 4'd0, '0, 0, 0);
    chk("lit_add_wb", int'(d_wbv), 1);
    chk("lit_add_tag", int'(d_tag), 5);
    step(0, 4'd0, '0, 0, 0);
    chk("lit_add_wb_late", int'(d_wbv), 0);

    // fmul then fcvt colliding on the writeback port
    step(1, 4'd2, 6'd1, 0, 0);
    step(1, 4'd5, 6'd2, 0, 0);
    chk("lit_cvt_stall", int'(d_rdy), 0);
    step(1, 4'd5, 6'd2, 0, 0);
    chk("lit_cvt_acc", int'(d_rdy), 1);
    chk("lit_mul_tag", int'(d_tag), 1);
    step(0, 4'd0, '0, 0, 0);
    chk("lit_cvt_wb", int'(d_wbv), 1);
    chk("lit_cvt_tag", int'(d_tag), 2);

    // Illegal opcode
    step(1, 4'd12, 6'd9, 0, 0);
    chk("lit_ill_rdy", int'(d_rdy), 1);
    step(0, 4'd0, '0, 0, 0);
    chk("lit_ill_unit", int'(d_iu), 4);
    chk("lit_ill_wb", int'(d_wbv), 1);
    chk("lit_ill_flag", int'(d_ill), 1);
    chk("lit_ill_tag", int'(d_tag), 9);

    // fdiv then fsqrt back to back
    step(1, 4'd3, 6'd10, 0, 0);
    for (int i = 0; i < 9; i++) begin
      step(1, 4'd4, 6'd11, 0, 0);
      chk("lit_sqrt_stall", int'(d_rdy), 0);
      chk("lit_div_busy", int'(d_busy), 1);
    end
    step(1, 4'd4, 6'd11, 0, 0);
    chk("lit_sqrt_acc", int'(d_rdy), 1);
    chk("lit_div_wb_tag", int'(d_tag), 10);
    idle(12);

    // fdiv killed by flush
    step(1, 4'd3, 6'd20, 0, 0);
    idle(3);
    step(0, 4'd0, '0, 1, 0);
    step(1, 4'd3, 6'd21, 0, 0);
    chk("lit_flush_rdy", int'(d_rdy), 1);
    chk("lit_flush_busy", int'(d_busy), 0);
    idle(12);

    // Randomized traffic; an unaccepted op is held stable
    pv = 0; pop = '0; ptag = '0;
    for (int i = 0; i < 1500; i++) begin
      fl = ($urandom_range(0, 99) < 3);
      rs = ($urandom_range(0, 299) == 0);
      if (!pv) begin
        pv   = ($urandom_range(0, 99) < 70);
        pop  = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
        ptag = TAG_W'($urandom);
      end
      step(pv, pop, ptag, fl, rs);
      if (pv && m_rdy) pv = 0;
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fpu_issue_sched.md
Name: fpu_issue_sched

Overview:
Issue and writeback scheduler for the single-precision FPU cluster: fadd/fsub, fmul, the iterative fdiv/fsqrt unit, and the 1-cycle conversion/sign units (fcvt.w.s, fcvt.s.w, fsgnj).
- Accepts one FP op per cycle from decode.
- Emits a start strobe to the target unit.
- Reserves the single shared FP writeback port at the op's fixed latency.
- Stalls decode on a port collision or while the iterative unit is busy.
- Drives the writeback tag so the register-file write side knows which result lands.

Parameters:
- TAG_W, 6: width of the destination tag carried with each op.
- LAT_ADD, 2: cycles from issue to writeback for fadd/fsub.
- LAT_MUL, 2: cycles from issue to writeback for fmul.
- LAT_DIV, 10: issue to writeback for fdiv and fsqrt; also the occupancy of the shared iterative unit.
- LAT_CVT, 1: issue to writeback for fcvt.w.s, fcvt.s.w, fsgnj and illegal ops.
- MAX_LAT, 16: depth of the reservation table; must be at least the largest LAT_* value.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discards all pending writebacks and frees the iterative unit
- in_valid  in  1  decode offers an op
- in_op  in  4  opcode: 0 fadd, 1 fsub, 2 fmul, 3 fdiv, 4 fsqrt, 5 fcvt.w.s, 6 fcvt.s.w, 7 fsgnj, 8-15 illegal
- in_tag  in  TAG_W  destination tag
- in_ready  out  1  op accepted this cycle when in_valid && in_ready (combinational)
- issue_valid  out  1  registered start strobe, 1 cycle wide
- issue_unit  out  3  0 add, 1 mul, 2 div/sqrt, 3 cvt/sgnj, 4 none (illegal)
- issue_sub  out  2  sub-op within unit: add/sub, div/sqrt, w.s/s.w/sgnj
- wb_valid  out  1  result writes back this cycle
- wb_tag  out  TAG_W  tag of the writing op
- wb_illegal  out  1  qualifies wb_valid; the op was illegal, so record an exception and write no data
- div_busy  out  1  iterative unit occupied

Behaviour:
- Reset: every registered output is 0, the reservation table is clear, the busy counter is 0, and in_ready = 0 while rst is high.
- Reset mid-operation behaves exactly like flush plus clearing the registered outputs.
- Latency L is chosen by opcode. An op accepted at edge t has issue_valid high in cycle t+1 and wb_valid/wb_tag high in exactly cycle t+L.
- Reservation table: MAX_LAT entries of {valid, tag, illegal}, where entry k means "writes back k cycles from now".
  - Every edge the table shifts one position toward 0, and entry 0 drives the wb_* registers.
  - An accepted op is inserted at its slot in the same edge as the shift.
- in_ready = !rst && !flush && !slot_taken(L(in_op)) && !(in_op is fdiv/fsqrt && div_busy_next). The slot check is evaluated against the post-shift table.
- in_ready may depend on in_op. Decode must hold in_valid, in_op and in_tag stable until accepted.
- Iterative unit:
  - Counter loads LAT_DIV on a div/sqrt accept and decrements to 0.
  - div_busy = (counter != 0).
  - A new div/sqrt is accepted in the same cycle the counter would reach 0, i.e. back-to-back issues exactly LAT_DIV cycles apart.
- Out-of-order writeback is legal; ordering is resolved by tag downstream. The writeback port never stalls.
- Illegal opcode: accepted with latency LAT_CVT, issue_unit = 4, and wb_illegal = 1 at writeback.
- Flush:
  - Clears the table and the busy counter at the edge.
  - in_ready = 0 during the flush cycle.
  - wb_valid is 0 from the following cycle onward.
  - A writeback registered before the flush edge still appears in the current cycle.
- Simultaneous events:
  - An op whose writeback lands in the same cycle another issues does not conflict; only equal writeback cycles conflict.
  - Flush and in_valid together: the op is dropped and not accepted.

Test Plan:
- fadd, tag 5, issued at t0 -> issue_valid at t0+1 with unit 0; wb_valid with tag 5 at t0+2 only.
- fmul (tag 1) at t0, then fcvt.w.s (tag 2) at t0+1 -> both land at t0+2, so fcvt in_ready = 0 at t0+1. fcvt is accepted at t0+2 and writes back at t0+3.
- fdiv at t0, fsqrt offered from t0+1 -> in_ready low through t0+9, accepted at t0+10. Writebacks at t0+10 and t0+20; div_busy stays high across the whole interval.
- Opcode 12, tag 9 -> accepted, issue_unit 4; at t0+1, wb_valid = 1, wb_illegal = 1, wb_tag 9.
- fdiv at t0, flush at t0+4 -> no wb at t0+10; div_busy = 0 from t0+5; fdiv accepted at t0+5.
- rst held 3 cycles with in_valid = 1 -> in_ready = 0 and all outputs 0. The first accept happens on the cycle after rst drops.
